square_fall_animator: RTL
=========================

Name: square_fall_animator

Overview:
- Consumes the periodic frame-rate `enable` tick from the game's delay/frame counter and animates one falling square on the 160x120 VGA adapter.
- On each tick it erases the square at its current position, advances it downward, then redraws it.
- Output is a pixel stream of one pixel per cycle, driven by a plot strobe with x, y and colour.
- Sits between the frame-pacing counter and the VGA adapter's plot port.

Parameters:
- SIZE, 4, square edge in pixels (1..15).
- STEP, 1, pixels moved down per tick (1..15).
- X_MAX, 160, screen width in pixels.
- Y_MAX, 120, screen height in pixels.
- X_INIT, 0, x position after reset.
- COLOUR, 3'b100, draw colour. Erase colour is fixed at 3'b000.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  frame tick, one-cycle pulse from the frame counter
- x_seed  in  8  x position loaded when the square wraps to the top
- plot  out  1  pixel write strobe to the VGA adapter
- x_out  out  8  pixel x
- y_out  out  7  pixel y
- colour  out  3  pixel colour
- busy  out  1  high while erasing, updating or drawing
- wrapped  out  1  one-cycle pulse when the square wraps to the top
- overrun  out  1  sticky flag: a tick was dropped

Behaviour:
- Reset values:
  - x = X_INIT, y = 0, state IDLE.
  - pending = 0, row = col = 0.
  - plot = 0, x_out = 0, y_out = 0, colour = 0.
  - busy = 0, wrapped = 0, overrun = 0.
- Reset mid-operation returns everything to the reset values on that edge. No further plot pulses follow.
- State IDLE:
  - busy = 0.
  - If `enable` is high or pending = 1: go to ERASE next cycle, clear pending, row = col = 0.
- State ERASE:
  - Lasts SIZE*SIZE cycles, one per pixel, row-major with col incrementing fastest.
  - Outputs per cycle are registered: plot = 1, x_out = x + col, y_out = y + row, colour = 000.
  - After pixel (SIZE-1, SIZE-1), go to UPDATE.
- State UPDATE (one cycle, plot = 0):
  - If y + STEP > Y_MAX - SIZE:
    - y <= 0.
    - x <= min(x_seed, X_MAX - SIZE).
    - wrapped = 1 for this cycle.
  - Otherwise y <= y + STEP.
  - Comparison is done in 8-bit arithmetic so there is no 7-bit overflow.
  - Then go to DRAW with row = col = 0.
- State DRAW:
  - Same scan as ERASE, using the updated x and y, colour = COLOUR.
  - Then go to IDLE.
- Latency and timing:
  - Tick sampled at edge t → first erase pixel is registered at t+1.
  - busy is high for exactly 2*SIZE*SIZE + 1 cycles per tick.
  - plot is never high in IDLE or UPDATE.
- Tick while busy:
  - Sets pending. It is serviced immediately after DRAW completes, with no intervening IDLE cycle.
  - A tick arriving while pending is already 1 is dropped and sets overrun. Only reset clears overrun.
  - A tick in the final DRAW cycle counts as pending.
- The first tick after reset erases a square that was never drawn. This is harmless because it writes black.
- Pixel coordinates never exceed X_MAX-1 or Y_MAX-1, given the clamping and wrap rules above.

Optional Feature:
- Macro: ANIM_TRAIL_EN.
- Defined:
  - The ERASE state is skipped; IDLE goes directly to UPDATE, leaving a trail.
  - busy lasts SIZE*SIZE + 1 cycles.
  - Pending and overrun rules are unchanged.
- Undefined: erase/update/draw exactly as described in Behaviour.

Test Plan:
- Reset, then a single `enable` pulse (SIZE=4, STEP=1, X_INIT=0):
  - 16 plots with colour 000 at (0..3, 0..3).
  - Then 1 idle cycle.
  - Then 16 plots with colour 100 at (0..3, 1..4).
  - busy is high for 33 cycles; afterwards busy = 0.
- Wrap: drive ticks until y = 116, with x_seed = 200:
  - The next update gives wrapped = 1 for one cycle, y = 0, x = 156 (clamped).
  - The draw covers x 156..159, y 0..3.
- Tick during ERASE, then another tick during DRAW:
  - Second pass starts the cycle after the last draw pixel.
  - The extra tick sets overrun = 1, and overrun stays 1.
- Assert reset in the middle of DRAW (pixel 7):
  - The next cycle has plot = 0, busy = 0, x = X_INIT, y = 0.
  - No plot pulse occurs until the next tick.
- Ticks spaced exactly 33 cycles apart:
  - No overrun; 32 plot pulses per tick; y increments by 1 each tick.
- With ANIM_TRAIL_EN defined:
  - Single tick → no colour-000 plots.
  - 16 draw plots at y 1..4.
  - busy high for 17 cycles.

Source files
------------

// File: rtl/square_fall_animator.sv
// Animates one falling square on a 160x120 VGA plot port: erase, move down, redraw per frame tick.
// Optional ANIM_TRAIL_EN skips the erase pass so the square leaves a trail.
module square_fall_animator #(
    parameter int          SIZE   = 4,
    parameter int          STEP   = 1,
    parameter int          X_MAX  = 160,
    parameter int          Y_MAX  = 120,
    parameter int          X_INIT = 0,
    parameter logic [2:0]  COLOUR = 3'b100
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] x_seed,
    output logic       plot,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] colour,
    output logic       busy,
    output logic       wrapped,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, ERASE, UPDATE, DRAW} state_t;

    localparam logic [3:0] LAST    = 4'(SIZE - 1);
    localparam logic [7:0] STEP8   = 8'(STEP);
    localparam logic [6:0] STEP7   = 7'(STEP);
    localparam logic [7:0] Y_LIMIT = 8'(Y_MAX - SIZE);
    localparam logic [7:0] X_LIMIT = 8'(X_MAX - SIZE);
    localparam logic [7:0] X_START = 8'(X_INIT);

`ifdef ANIM_TRAIL_EN
    localparam state_t START = UPDATE;
`else
    localparam state_t START = ERASE;
`endif

    state_t     state_reg, state_next;
    logic [7:0] x_reg, x_next;
    logic [6:0] y_reg, y_next;
    logic [3:0] row_reg, row_next;
    logic [3:0] col_reg, col_next;
    logic       pending_reg, pending_next;
    logic       overrun_reg, overrun_next;

    logic       plot_reg, plot_next;
    logic [7:0] x_out_reg, x_out_next;
    logic [6:0] y_out_reg, y_out_next;
    logic [2:0] colour_reg, colour_next;
    logic       busy_reg, busy_next;
    logic       wrapped_reg, wrapped_next;

    logic       last_px;
    logic [7:0] y_sum;

    assign last_px = (row_reg == LAST) && (col_reg == LAST);
    assign y_sum   = {1'b0, y_reg} + STEP8;

    always_comb begin
        state_next   = state_reg;
        x_next       = x_reg;
        y_next       = y_reg;
        row_next     = row_reg;
        col_next     = col_reg;
        pending_next = pending_reg;
        overrun_next = overrun_reg;
        plot_next    = 1'b0;
        x_out_next   = x_reg + {4'b0000, col_reg};
        y_out_next   = y_reg + {3'b000, row_reg};
        colour_next  = 3'b000;
        busy_next    = (state_reg != IDLE);
        wrapped_next = 1'b0;

        // A tick while busy is queued once; a second one is lost and flagged.
        if (state_reg != IDLE && enable) begin
            if (pending_reg)
                overrun_next = 1'b1;
            else
                pending_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (enable || pending_reg) begin
                    state_next   = START;
                    pending_next = 1'b0;
                    row_next     = '0;
                    col_next     = '0;
                end
            end
            ERASE, DRAW: begin
                plot_next   = 1'b1;
                colour_next = (state_reg == DRAW) ? COLOUR : 3'b000;
                if (last_px) begin
                    row_next = '0;
                    col_next = '0;
                    if (state_reg == ERASE) begin
                        state_next = UPDATE;
                    end else if (pending_reg || enable) begin
                        // Back-to-back service keeps busy continuous.
                        state_next   = START;
                        pending_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (col_reg == LAST) begin
                    col_next = '0;
                    row_next = row_reg + 4'd1;
                end else begin
                    col_next = col_reg + 4'd1;
                end
            end
            UPDATE: begin
                if (y_sum > Y_LIMIT) begin
                    y_next       = '0;
                    x_next       = (x_seed > X_LIMIT) ? X_LIMIT : x_seed;
                    wrapped_next = 1'b1;
                end else begin
                    y_next = y_reg + STEP7;
                end
                row_next   = '0;
                col_next   = '0;
                state_next = DRAW;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= IDLE;
            x_reg       <= X_START;
            y_reg       <= '0;
            row_reg     <= '0;
            col_reg     <= '0;
            pending_reg <= 1'b0;
            overrun_reg <= 1'b0;
            plot_reg    <= 1'b0;
            x_out_reg   <= '0;
            y_out_reg   <= '0;
            colour_reg  <= '0;
            busy_reg    <= 1'b0;
            wrapped_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            x_reg       <= x_next;
            y_reg       <= y_next;
            row_reg     <= row_next;
            col_reg     <= col_next;
            pending_reg <= pending_next;
            overrun_reg <= overrun_next;
            plot_reg    <= plot_next;
            x_out_reg   <= x_out_next;
            y_out_reg   <= y_out_next;
            colour_reg  <= colour_next;
            busy_reg    <= busy_next;
            wrapped_reg <= wrapped_next;
        end
    end

    assign plot    = plot_reg;
    assign x_out   = x_out_reg;
    assign y_out   = y_out_reg;
    assign colour  = colour_reg;
    assign busy    = busy_reg;
    assign wrapped = wrapped_reg;
    assign overrun = overrun_reg;

endmodule
